// File: rtl/mac_accumulate_stage.sv
// Accumulates bursts of unsigned multiplier products into a wider sum.
// A burst closes on prod_last or at MAX_TERMS; the result is held on a valid/ready output.
module mac_accumulate_stage #(
  parameter int PROD_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int MAX_TERMS  = 16,
  parameter int SATURATE   = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [PROD_WIDTH-1:0]            prod_in,
  input  logic                             prod_valid,
  input  logic                             prod_last,
  output logic                             prod_ready,
  output logic [ACC_WIDTH-1:0]             acc_out,
  output logic [$clog2(MAX_TERMS+1)-1:0]   term_count,
  output logic                             overflow,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int CW = $clog2(MAX_TERMS+1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_TERMS);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                state;
  logic [ACC_WIDTH-1:0]  acc;
  logic [CW-1:0]         count;
  logic                  ovf;

  logic                  accept;
  logic [ACC_WIDTH:0]    sum;
  logic                  carry;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic [CW-1:0]         count_next;
  logic                  ovf_next;
  logic                  close_burst;

  assign prod_ready = !reset && (state != HOLD);
  assign accept     = prod_valid && prod_ready;

  // count is zero in IDLE, so the MAX_CNT compare also covers MAX_TERMS == 1
  always_comb begin
    sum         = {1'b0, acc} + {{(ACC_WIDTH+1-PROD_WIDTH){1'b0}}, prod_in};
    carry       = sum[ACC_WIDTH];
    acc_next    = sum[ACC_WIDTH-1:0];
    if (carry && (SATURATE != 0))
      acc_next  = '1;
    count_next  = count + 1'b1;
    ovf_next    = ovf | carry;
    close_burst = prod_last || (count_next == MAX_CNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      acc_out    <= '0;
      term_count <= '0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            if (close_burst) begin
              acc_out    <= acc_next;
              term_count <= count_next;
              overflow   <= ovf_next;
              out_valid  <= 1'b1;
              acc        <= '0;
              count      <= '0;
              ovf        <= 1'b0;
              state      <= HOLD;
            end else begin
              acc        <= acc_next;
              count      <= count_next;
              ovf        <= ovf_next;
              state      <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulate_stage.sv
// Drives three lockstep instances (16-bit wrap, 9-bit wrap, 9-bit saturate) from one stimulus
// and checks each closed burst against a reference model through an expected-result queue.
module tb_mac_accumulate_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  prod_in;
  logic        prod_valid;
  logic        prod_last;
  logic        out_ready;

  logic        prod_ready_a, prod_ready_b, prod_ready_c;
  logic [15:0] acc_out_a;
  logic [8:0]  acc_out_b, acc_out_c;
  logic [4:0]  term_count_a, term_count_b, term_count_c;
  logic        overflow_a, overflow_b, overflow_c;
  logic        out_valid_a, out_valid_b, out_valid_c;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int acc0;
    int acc1;
    int acc2;
    int cnt;
    bit ovf0;
    bit ovf1;
    bit ovf2;
  } exp_t;

  exp_t exp_q[$];
  exp_t held;

  int acc_w   [3] = '{16, 9, 9};
  bit acc_sat [3] = '{1'b0, 1'b0, 1'b1};
  int m_acc   [3];
  bit m_ovf   [3];
  int m_cnt;

  always #5 clk = ~clk;

  mac_accumulate_stage #(.PROD_WIDTH(8), .ACC_WIDTH(16), .MAX_TERMS(16), .SATURATE(0)) u_dut_a (
    .clk(clk), .reset(reset), .prod_in(prod_in), .prod_valid(prod_valid), .prod_last(prod_last),
    .prod_ready(prod_ready_a), .acc_out(acc_out_a), .term_count(term_count_a),
    .overflow(overflow_a), .out_valid(out_valid_a), .out_ready(out_ready));

  mac_accumulate_stage #(.PROD_WIDTH(8), .ACC_WIDTH(9), .MAX_TERMS(16), .SATURATE(0)) u_dut_b (
    .clk(clk), .reset(reset), .prod_in(prod_in), .prod_valid(prod_valid), .prod_last(prod_last),
    .prod_ready(prod_ready_b), .acc_out(acc_out_b), .term_count(term_count_b),
    .overflow(overflow_b), .out_valid(out_valid_b), .out_ready(out_ready));

  mac_accumulate_stage #(.PROD_WIDTH(8), .ACC_WIDTH(9), .MAX_TERMS(16), .SATURATE(1)) u_dut_c (
    .clk(clk), .reset(reset), .prod_in(prod_in), .prod_valid(prod_valid), .prod_last(prod_last),
    .prod_ready(prod_ready_c), .acc_out(acc_out_c), .term_count(term_count_c),
    .overflow(overflow_c), .out_valid(out_valid_c), .out_ready(out_ready));

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic modelClear();
    for (int c = 0; c < 3; c++) begin
      m_acc[c] = 0;
      m_ovf[c] = 1'b0;
    end
    m_cnt = 0;
  endtask

  task automatic modelAccept(input int p, input bit last);
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      int lim;
      int s;
      lim = 1 << acc_w[c];
      s   = m_acc[c] + p;
      if (s >= lim) begin
        m_ovf[c] = 1'b1;
        m_acc[c] = acc_sat[c] ? lim - 1 : s - lim;
      end else begin
        m_acc[c] = s;
      end
    end
    m_cnt++;
    if (last || m_cnt == 16) begin
      e.acc0 = m_acc[0]; e.acc1 = m_acc[1]; e.acc2 = m_acc[2];
      e.ovf0 = m_ovf[0]; e.ovf1 = m_ovf[1]; e.ovf2 = m_ovf[2];
      e.cnt  = m_cnt;
      exp_q.push_back(e);
      modelClear();
    end
  endtask

  // Holds prod_valid until the stage is ready, then lets exactly one edge accept the product
  task automatic applyStimulus(input int p, input bit last);
    int waited;
    prod_valid = 1'b1;
    prod_in    = 8'(p);
    prod_last  = last;
    waited     = 0;
    @(negedge clk);
    while (!prod_ready_a && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checkVal("accept_ready", 32'(prod_ready_a), 32'd1);
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    modelAccept(p, last);
  endtask

  task automatic checkHeld(input string tag);
    checkVal({tag, "_acc_a"},   32'(acc_out_a),    32'(held.acc0));
    checkVal({tag, "_acc_b"},   32'(acc_out_b),    32'(held.acc1));
    checkVal({tag, "_acc_c"},   32'(acc_out_c),    32'(held.acc2));
    checkVal({tag, "_cnt_a"},   32'(term_count_a), 32'(held.cnt));
    checkVal({tag, "_cnt_b"},   32'(term_count_b), 32'(held.cnt));
    checkVal({tag, "_cnt_c"},   32'(term_count_c), 32'(held.cnt));
    checkVal({tag, "_ovf_a"},   32'(overflow_a),   32'(held.ovf0));
    checkVal({tag, "_ovf_b"},   32'(overflow_b),   32'(held.ovf1));
    checkVal({tag, "_ovf_c"},   32'(overflow_c),   32'(held.ovf2));
  endtask

  task automatic checkOutput(input string tag);
    int waited;
    waited = 0;
    while (!out_valid_a && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkVal({tag, "_latency"}, 32'(waited), 32'd0);
    checkVal({tag, "_valid_a"}, 32'(out_valid_a), 32'd1);
    checkVal({tag, "_valid_b"}, 32'(out_valid_b), 32'd1);
    checkVal({tag, "_valid_c"}, 32'(out_valid_c), 32'd1);
    checkVal({tag, "_queued"},  32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      held = exp_q.pop_front();
      checkHeld(tag);
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkVal({tag, "_hs_valid_a"}, 32'(out_valid_a), 32'd0);
    checkVal({tag, "_hs_valid_c"}, 32'(out_valid_c), 32'd0);
    checkVal({tag, "_hs_ready_a"}, 32'(prod_ready_a), 32'd1);
    checkVal({tag, "_hs_ready_b"}, 32'(prod_ready_b), 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    prod_in    = 8'd0;
    prod_valid = 1'b1;
    prod_last  = 1'b0;
    out_ready  = 1'b0;
    modelClear();

    // Reset state, with prod_valid high to show nothing is taken
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_ready", 32'(prod_ready_a), 32'd0);
    checkVal("rst_valid", 32'(out_valid_a), 32'd0);
    checkVal("rst_acc",   32'(acc_out_a), 32'd0);
    checkVal("rst_cnt",   32'(term_count_a), 32'd0);
    checkVal("rst_ovf",   32'(overflow_a), 32'd0);
    reset      = 1'b0;
    prod_valid = 1'b0;
    #1;
    checkVal("post_rst_ready", 32'(prod_ready_a), 32'd1);

    // Basic burst 3+5+7
    applyStimulus(3, 1'b0);
    applyStimulus(5, 1'b0);
    applyStimulus(7, 1'b1);
    checkOutput("basic");
    handshake("basic");

    // 16 x 255 closes at MAX_TERMS; a 17th product waits for the handshake
    for (int i = 0; i < 16; i++) applyStimulus(255, 1'b0);
    checkOutput("max16");
    prod_valid = 1'b1;
    prod_in    = 8'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkVal("max16_blocked", 32'(prod_ready_a), 32'd0);
      checkHeld("max16_stable");
    end
    prod_valid = 1'b0;
    handshake("max16");

    // Overflow burst; the 9-bit instances wrap / saturate
    applyStimulus(255, 1'b0);
    applyStimulus(255, 1'b0);
    applyStimulus(10, 1'b1);
    checkOutput("ovf");
    handshake("ovf");

    // Back-pressure while the multiplier keeps offering 9
    applyStimulus(20, 1'b0);
    applyStimulus(30, 1'b1);
    checkOutput("bp");
    prod_valid = 1'b1;
    prod_in    = 8'd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkVal("bp_ready", 32'(prod_ready_a), 32'd0);
      checkVal("bp_valid", 32'(out_valid_a), 32'd1);
      checkHeld("bp_stable");
    end
    handshake("bp");
    applyStimulus(9, 1'b1);
    checkOutput("bp_next");
    handshake("bp_next");

    // Gapped burst; prod_last without prod_valid and out_ready without out_valid do nothing
    applyStimulus(1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      prod_last = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkVal("gap_no_close", 32'(out_valid_a), 32'd0);
    end
    prod_last = 1'b0;
    out_ready = 1'b0;
    applyStimulus(2, 1'b1);
    checkOutput("gap");
    handshake("gap");

    // Single-term burst
    applyStimulus(42, 1'b1);
    checkOutput("single");
    handshake("single");

    // prod_last on the 16th term closes exactly one burst
    for (int i = 0; i < 15; i++) applyStimulus(i, 1'b0);
    applyStimulus(100, 1'b1);
    checkOutput("last_at_max");
    handshake("last_at_max");
    repeat (2) @(posedge clk);
    #1;
    checkVal("no_double_close", 32'(out_valid_a), 32'd0);

    // Mid-burst reset discards the partial sum
    applyStimulus(100, 1'b0);
    applyStimulus(50, 1'b0);
    reset = 1'b1;
    #1;
    checkVal("midrst_ready", 32'(prod_ready_a), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelClear();
    checkVal("midrst_valid", 32'(out_valid_a), 32'd0);
    applyStimulus(4, 1'b1);
    checkOutput("after_rst");

    // Reset while holding a result drops it
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkVal("holdrst_valid_a", 32'(out_valid_a), 32'd0);
    checkVal("holdrst_valid_b", 32'(out_valid_b), 32'd0);
    #1;
    checkVal("holdrst_ready", 32'(prod_ready_a), 32'd1);
    checkVal("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
